// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32M sequential multiplier: operand width,
// the M-extension funct3[1:0] encodings, the controller state type and a
// helper that turns a possibly-signed operand into its magnitude.
package rv32_pkg;

    localparam int XLEN = 32;

    // RV32M funct3[1:0] for the multiply group
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Magnitude of v when interpreted as signed. The most negative value maps
    // onto itself, which read as unsigned is exactly 2^(XLEN-1).
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/adder_64.sv
// 64-bit ripple-carry adder built from a chain of one-bit full-adder cells.
module adder_64 (
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic        cin,
    output logic [63:0] s,
    output logic        cout
);

    // One full-adder cell: returns {carry_out, sum}
    function automatic logic [1:0] full_adder(input logic xi,
                                              input logic yi,
                                              input logic ci);
        return {(xi & yi) | (ci & (xi ^ yi)), xi ^ yi ^ ci};
    endfunction

    // Ripple the carry from bit 0 up to bit 63
    always_comb begin
        logic carry;
        carry = cin;
        s     = '0;
        for (int i = 0; i < 64; i++) begin
            {carry, s[i]} = full_adder(x[i], y[i], carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU
// group. Operands are reduced to magnitudes on acceptance, multiplied over
// 32 CALC cycles, and the sign is restored in a single FIX cycle.
//
// Build option: define SEQ_MULT_EARLY_TERM_EN to leave CALC as soon as the
// remaining multiplier is zero; results are identical, only latency changes.
//
// Handshake: start is a request that is sampled only while busy=0 (IDLE);
// the cycle after acceptance busy rises and stays high until and including
// the single cycle in which done=1, during which result carries the new
// product word. Requests while busy=1 (including the done cycle) are dropped.
// result holds its value until the next operation overwrites it.
module seq_multiplier
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e              state;
    logic [1:0]          op_q;
    logic [2*XLEN-1:0]   product;
    logic [2*XLEN-1:0]   multiplicand;
    logic [XLEN-1:0]     multiplier;
    logic                negate;
    logic [5:0]          count;

    logic                a_signed;
    logic                b_signed;
    logic [2*XLEN-1:0]   add_x;
    logic [2*XLEN-1:0]   add_y;
    logic                add_cin;
    logic [2*XLEN-1:0]   add_s;
    logic                unused_cout;
    logic [2*XLEN-1:0]   fixed_product;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Signedness of the incoming operands for the requested op
    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU);
    assign b_signed = (op == OP_MULH);

    // One adder serves both the accumulate step and the final negation
    always_comb begin
        add_x   = product;
        add_y   = '0;
        add_cin = 1'b0;
        if (state == ST_CALC && multiplier[0]) begin
            add_y = multiplicand;
        end
        if (state == ST_FIX) begin
            add_x   = ~product;
            add_cin = 1'b1;
        end
    end

    adder_64 u_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .s    (add_s),
        .cout (unused_cout)
    );

    // Product after sign restoration, valid while in FIX
    assign fixed_product = negate ? add_s : product;

    // Controller and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_q         <= 2'b00;
            product      <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            negate       <= 1'b0;
            count        <= '0;
            result       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q         <= op;
                        multiplicand <= {{XLEN{1'b0}}, magnitude(a, a_signed)};
                        multiplier   <= magnitude(b, b_signed);
                        negate       <= (a_signed & a[XLEN-1]) ^ (b_signed & b[XLEN-1]);
                        product      <= '0;
                        count        <= '0;
                        state        <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    product      <= add_s;
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    count        <= count + 6'd1;
                    if (count == 6'd31) begin
                        state <= ST_FIX;
                    end
`ifdef SEQ_MULT_EARLY_TERM_EN
                    // Remaining multiplier bits are all zero: nothing left to add
                    if (multiplier[XLEN-1:1] == '0) begin
                        state <= ST_FIX;
                    end
`endif
                end
                ST_FIX: begin
                    // Result is registered here so it is already valid with done
                    product <= fixed_product;
                    result  <= (op_q == OP_MUL) ? fixed_product[XLEN-1:0]
                                                : fixed_product[2*XLEN-1:XLEN];
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: a cycle-level behavioural model
// (signed 64-bit arithmetic plus an expected-result queue) is compared with
// busy/done/result on every falling edge; directed cases pin the model with
// literal values, then randomized traffic runs against it.
module tb_seq_multiplier;
    import rv32_pkg::*;

`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int compared   = 0;
    int mismatched = 0;

    seq_multiplier dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [1:0] o,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        logic signed [63:0] sx, sy, p;
        sx = ((o == OP_MULH || o == OP_MULHSU) && x[31]) ? {32'hFFFF_FFFF, x} : {32'h0, x};
        sy = ((o == OP_MULH) && y[31]) ? {32'hFFFF_FFFF, y} : {32'h0, y};
        p  = sx * sy;
        return (o == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] y);
        logic [31:0] m;
        int hb;
        if (!ET) return 34;
        m  = (o == OP_MULH && y[31]) ? (32'd0 - y) : y;
        hb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) hb = i;
        return 3 + hb;
    endfunction

    int          cyc      = 0;
    bit          active   = 1'b0;
    int          done_at  = -1;
    bit          model_ok = 1'b0;
    logic [31:0] shown    = '0;
    logic [31:0] exp_q[$];

    // Model advance at each rising edge using the inputs the DUT samples
    always @(posedge clk) begin : model
        bit acc;
        if (rst) begin
            active   = 1'b0;
            done_at  = -1;
            shown    = '0;
            exp_q.delete();
            model_ok = 1'b1;
        end else begin
            acc = !active && start;
            if (active && cyc == done_at) active = 1'b0;
            if (acc) begin
                active  = 1'b1;
                done_at = cyc + ref_latency(op, b);
                exp_q.push_back(ref_result(op, a, b));
            end
        end
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin : compare
        bit exp_done;
        if (model_ok) begin
            exp_done = active && (cyc == done_at);
            if (exp_done && exp_q.size() > 0) shown = exp_q.pop_front();
            check("busy", {31'd0, busy}, {31'd0, active});
            check("done", {31'd0, done}, {31'd0, exp_done});
            check("result", result, shown);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
    endtask

    // One operation from an idle DUT; checks literal result and latency
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] lit, input int lat);
        int n;
        int seen;
        logic [31:0] res;
        check({tag, "_model_res"}, ref_result(o, x, y), lit);
        check({tag, "_model_lat"}, ref_latency(o, y), lat);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        n = cyc;
        @(posedge clk); #1;
        drive_idle();
        seen = -1;
        res  = '0;
        for (int i = 0; i < 40 && seen < 0; i++) begin
            @(negedge clk);
            if (done) begin
                seen = cyc;
                res  = result;
            end
        end
        check({tag, "_latency"}, seen - n, lat);
        check({tag, "_result"}, res, lit);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stim
        int n;
        int dones;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);

        run_op("mul_7x6",      OP_MUL,    32'd7,         32'd6,         32'h0000_002A, ET ? 5 : 34);
        run_op("mulh_min",     OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_op("mulhsu_m1x2",  OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, ET ? 4 : 34);
        run_op("mulhu_max",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mul_max",      OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
        run_op("mulh_m3x5",    OP_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, ET ? 5 : 34);
        run_op("mul_5x1",      OP_MUL,    32'd5,         32'd1,         32'h0000_0005, ET ? 3 : 34);
        run_op("mul_bzero",    OP_MUL,    32'h1234_5678, 32'd0,         32'h0000_0000, ET ? 3 : 34);

        // Start re-asserted while busy must be ignored
        @(posedge clk); #1;
        start = 1'b1; op = OP_MUL; a = 32'd7; b = 32'h0000_FFFF;
        @(posedge clk); #1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1 start = 1'b1; op = OP_MULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        drive_idle();
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (dones == 1) check("busy_restart_result", result, 32'h0006_FFF9);
            end
        end
        check("busy_restart_dones", dones, 32'd1);

        // Reset in the middle of an operation aborts it
        @(posedge clk); #1;
        start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'h8000_0000;
        n = cyc;
        @(posedge clk); #1;
        drive_idle();
        while (cyc < n + 10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 32'd0);

        run_op("after_reset", OP_MULH, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, ET ? 4 : 34);
        run_op("after_reset_lo", OP_MUL, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0006, 34);

        // Randomized traffic, including starts while busy and rare resets
        for (int i = 0; i < 45000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) != 0);
            op    = 2'($urandom_range(0, 3));
            a     = rand_operand();
            b     = rand_operand();
            rst   = ($urandom_range(0, 4999) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
